// File: rtl/arb_pkg.sv
// Shared types and helpers for the mux_4 round-robin arbiter.
// Used by mux_4_arbiter and rr_pick.
package arb_pkg;

    localparam int REQ_N = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(
        input logic [REQ_N-1:0] oh
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-priority encoder: first masked request after last wins.
// Search order is last+1, last+2, last+3, last (mod 4).
module rr_pick
    import arb_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic [REQ_N-1:0] mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [REQ_N-1:0] cand;
    logic [IDX_W-1:0] pos;

    assign cand = req & mask;

    always_comb begin
        found = 1'b0;
        idx   = last;
        pos   = last;
        for (int k = 1; k <= REQ_N; k++) begin
            pos = last + IDX_W'(k);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_4_arbiter.sv
// Round-robin owner of a shared mux_4 selector with registered grants.
// Optional burst limit: define MUX_4_ARBITER_BURST_LIMIT_EN.
module mux_4_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] req,
    output logic [REQ_N-1:0] grant,
    output logic [IDX_W-1:0] selector,
    output logic             valid
);

    arb_state_t       state_q, state_d;
    logic [REQ_N-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;

    logic             owner_req;
    logic [REQ_N-1:0] mask;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    if (MAX_BURST < 2 || MAX_BURST > 255 || CNT_W < 1) begin : g_bad_max_burst
    end

`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // The current owner never competes; in IDLE grant_q is zero so all pass.
    assign mask      = ~grant_q;
    assign owner_req = |(req & grant_q);

    rr_pick u_pick (
        .req   (req),
        .last  (last_q),
        .mask  (mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    grant_d = REQ_N'(1) << pick_idx;
                    last_d  = pick_idx;
                    valid_d = 1'b1;
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        grant_d = REQ_N'(1) << pick_idx;
                        last_d  = pick_idx;
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
                else if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_d = REQ_N'(1) << pick_idx;
                        last_d  = pick_idx;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
        endcase
        // Selector follows the grant; it holds its value through IDLE.
        if (|grant_d) sel_d = onehot_to_idx(grant_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= IDX_W'(REQ_N - 1);
            valid_q <= 1'b0;
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign selector = sel_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Scoreboard bench for mux_4_arbiter: directed vectors, queued expectations.
// Burst-limit vectors follow MUX_4_ARBITER_BURST_LIMIT_EN with MAX_BURST=4.
module tb_mux_4_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] selector;
    logic       valid;

    int tests  = 0;
    int failed = 0;

    logic [6:0] exp_q[$];

    mux_4_arbiter #(.MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .selector (selector),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] g, input logic [1:0] s);
        @(negedge clk);
        rst = r;
        req = rq;
        exp_q.push_back({g, s, |g});
    endtask

    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({grant, selector, valid} !== e) begin
                failed++;
                $display("FAIL cyc%0d: got g=%b s=%0d v=%b, want g=%b s=%0d v=%b",
                         tests, grant, selector, valid, e[6:3], e[2:1], e[0]);
            end
        end
    end

    initial begin
        // reset and idle
        step(1, 4'b0000, 4'b0000, 2'd0);
        step(1, 4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, 4'b0000, 2'd0);
        // rotation with direct handover
        step(0, 4'b1111, 4'b0001, 2'd0);
        step(0, 4'b1110, 4'b0010, 2'd1);
        step(0, 4'b1100, 4'b0100, 2'd2);
        step(0, 4'b1000, 4'b1000, 2'd3);
        step(0, 4'b0111, 4'b0001, 2'd0);
        // owner 2 holds then releases, selector stays 2
        step(0, 4'b0100, 4'b0100, 2'd2);
        step(0, 4'b0100, 4'b0100, 2'd2);
        step(0, 4'b0100, 4'b0100, 2'd2);
        step(0, 4'b0000, 4'b0000, 2'd2);
        step(0, 4'b0000, 4'b0000, 2'd2);
        // two constant requesters
`ifdef MUX_4_ARBITER_BURST_LIMIT_EN
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) begin
                if (b % 2 == 0) step(0, 4'b0011, 4'b0001, 2'd0);
                else            step(0, 4'b0011, 4'b0010, 2'd1);
            end
        end
`else
        for (int i = 0; i < 20; i++) step(0, 4'b0011, 4'b0001, 2'd0);
`endif
        // lone requester keeps the grant indefinitely
        for (int i = 0; i < 10; i++) step(0, 4'b0001, 4'b0001, 2'd0);
        // reset mid-grant
        step(0, 4'b1000, 4'b1000, 2'd3);
        step(0, 4'b1000, 4'b1000, 2'd3);
        step(1, 4'b1000, 4'b0000, 2'd0);
        step(0, 4'b1000, 4'b1000, 2'd3);
        step(0, 4'b0000, 4'b0000, 2'd3);
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
